// File: rtl/matmul_pkg.sv
// Shared types and helpers for the sequential signed matrix multiplier.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_e;

    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned k);
        return 2 * dw + int'($clog2(k)) + 1;
    endfunction

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    // Counter width that stays legal for a count of one
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : int'($clog2(n));
    endfunction

    function automatic longint sat_max(input int unsigned dw);
        return (longint'(1) <<< (dw - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int unsigned dw);
        return -(longint'(1) <<< (dw - 1));
    endfunction

endpackage

// File: rtl/matmul_mac_lane.sv
// One output-column MAC: signed multiply-accumulate, then shift and saturate/wrap to DW.
module matmul_mac_lane
    import matmul_pkg::*;
#(
    parameter int unsigned DW       = 8,
    parameter int unsigned AW       = 19,
    parameter int unsigned SHIFT    = 0,
    parameter int unsigned SATURATE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          en,
    input  logic          last,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y_c,
    output logic          sat_c
);

    localparam logic signed [AW-1:0] HI = AW'(sat_max(DW));
    localparam logic signed [AW-1:0] LO = AW'(sat_min(DW));

    logic signed [AW-1:0]     acc_q;
    logic signed [2*DW-1:0]   prod;
    logic signed [AW-1:0]     sum;
    logic signed [AW-1:0]     shr;

    assign prod = $signed(a) * $signed(b);
    assign sum  = acc_q + AW'(prod);
    assign shr  = sum >>> SHIFT;

    // Narrowing of the completed dot product; sat pulse only on the writing cycle
    always_comb begin
        y_c   = shr[DW-1:0];
        sat_c = 1'b0;
        if (SATURATE != 0) begin
            if (shr > HI) begin
                y_c   = HI[DW-1:0];
                sat_c = en && last;
            end else if (shr < LO) begin
                y_c   = LO[DW-1:0];
                sat_c = en && last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= last ? '0 : sum;
        end
    end

endmodule

// File: rtl/matmul_seq.sv
// Sequential handshaked signed matmul: LANES output columns per cycle, k innermost, then column block, then row.
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned M          = 128,
    parameter int unsigned K          = 128,
    parameter int unsigned N          = 128,
    parameter int unsigned LANES      = 8,
    parameter int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH, K),
    parameter int unsigned SHIFT      = 0,
    parameter int unsigned SATURATE   = 1
) (
    input  logic                         clk_p,
    input  logic                         rst_p,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH*M*K-1:0]    matrix1,
    input  logic [DATA_WIDTH*K*N-1:0]    matrix2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH*M*N-1:0]    mul,
    output logic                         sat_flag
);

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned JB = ceil_div(N, LANES);
    localparam int unsigned IW = cnt_width(M);
    localparam int unsigned JW = cnt_width(JB);
    localparam int unsigned KW = cnt_width(K);

    state_e                 state_q, state_d;
    logic                   in_ready_d, out_valid_d;
    logic                   load, step;

    logic [IW-1:0]          i_q;
    logic [JW-1:0]          jb_q;
    logic [KW-1:0]          k_q;
    logic                   last_i, last_jb, last_k;

    logic [DW*M*K-1:0]      a_q;
    logic [DW*K*N-1:0]      b_q;

    int unsigned            a_idx;
    int unsigned            col   [LANES];
    int unsigned            o_idx [LANES];
    logic [DW-1:0]          a_el;
    logic [DW-1:0]          b_el  [LANES];
    logic [LANES-1:0]       lane_en;
    logic [DW-1:0]          lane_y [LANES];
    logic [LANES-1:0]       lane_sat;

    assign last_i  = (i_q  == IW'(M - 1));
    assign last_jb = (jb_q == JW'(JB - 1));
    assign last_k  = (k_q  == KW'(K - 1));

    // Control: next state and next values of the registered handshake outputs
    always_comb begin
        state_d     = state_q;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        load        = 1'b0;
        step        = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready) begin
                    load       = 1'b1;
                    in_ready_d = 1'b0;
                    state_d    = COMPUTE;
                end
            end
            COMPUTE: begin
                step = 1'b1;
                if (last_k && last_jb && last_i) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                out_valid_d = 1'b1;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_p) begin
        if (rst_p) begin
            state_q   <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    // Loop nest counters: k innermost, then column block, then row
    always_ff @(posedge clk_p) begin
        if (rst_p || load) begin
            i_q  <= '0;
            jb_q <= '0;
            k_q  <= '0;
        end else if (step) begin
            if (!last_k) begin
                k_q <= k_q + KW'(1);
            end else begin
                k_q <= '0;
                if (!last_jb) begin
                    jb_q <= jb_q + JW'(1);
                end else begin
                    jb_q <= '0;
                    i_q  <= last_i ? '0 : i_q + IW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_p) begin
        if (load) begin
            a_q <= matrix1;
            b_q <= matrix2;
        end
    end

    // Operand element selection and per-lane column gating
    always_comb begin
        a_idx = (32'(i_q) * K + 32'(k_q)) * DW;
        for (int l = 0; l < LANES; l++) begin
            col[l]     = 32'(jb_q) * LANES + 32'(l);
            o_idx[l]   = (32'(i_q) * N + col[l]) * DW;
            lane_en[l] = step && (col[l] < N);
            b_el[l]    = '0;
            if (col[l] < N) begin
                b_el[l] = b_q[(32'(k_q) * N + col[l]) * DW +: DW];
            end
        end
    end

    assign a_el = a_q[a_idx +: DW];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        matmul_mac_lane #(
            .DW       (DW),
            .AW       (ACC_WIDTH),
            .SHIFT    (SHIFT),
            .SATURATE (SATURATE)
        ) u_lane (
            .clk   (clk_p),
            .rst   (rst_p),
            .clear (load),
            .en    (lane_en[l]),
            .last  (last_k),
            .a     (a_el),
            .b     (b_el[l]),
            .y_c   (lane_y[l]),
            .sat_c (lane_sat[l])
        );
    end

    // Result write-back at the end of each dot product
    always_ff @(posedge clk_p) begin
        if (rst_p) begin
            mul      <= '0;
            sat_flag <= 1'b0;
        end else if (load) begin
            sat_flag <= 1'b0;
        end else if (step && last_k) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_en[l]) begin
                    mul[o_idx[l] +: DW] <= lane_y[l];
                end
            end
            sat_flag <= sat_flag | (|lane_sat);
        end
    end

endmodule

// File: tb/tb_matmul_seq.sv
// Scoreboard bench for matmul_seq: several configurations run side by side against an arithmetic reference.
module tb_matmul_seq;

    localparam int NCFG   = 7;
    localparam int NRAND  = 200;

    // Config word nibbles: M, K, N, LANES, SHIFT, SATURATE
    function automatic int unsigned cfg(input int g, input int f);
        logic [23:0] w;
        case (g)
            0:       w = 24'h232201;
            1:       w = 24'h232200;
            2:       w = 24'h232221;
            3:       w = 24'h233101;
            4:       w = 24'h233401;
            5:       w = 24'h345210;
            default: w = 24'h213201;
        endcase
        return int'((w >> (4 * (5 - f))) & 24'hF);
    endfunction

    logic clk;
    int   cyc;
    int   errors;
    int   checks;
    int   done_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int g, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cfg%0d: got=%0h expected=%0h", name, g, got, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : cfg_g
        localparam int unsigned GM   = cfg(g, 0);
        localparam int unsigned GK   = cfg(g, 1);
        localparam int unsigned GN   = cfg(g, 2);
        localparam int unsigned GL   = cfg(g, 3);
        localparam int unsigned GSH  = cfg(g, 4);
        localparam int unsigned GSAT = cfg(g, 5);
        localparam int unsigned W1   = 8 * GM * GK;
        localparam int unsigned W2   = 8 * GK * GN;
        localparam int unsigned WO   = 8 * GM * GN;
        localparam int          LAT  = int'(GM * ((GN + GL - 1) / GL) * GK + 1);

        logic           rst, in_valid, in_ready, out_valid, out_ready, sat_flag;
        logic [W1-1:0]  m1;
        logic [W2-1:0]  m2;
        logic [WO-1:0]  mul;
        int             ready_mode;
        int             a [GM][GK];
        int             b [GK][GN];
        logic [WO-1:0]  q_mul [$];
        bit             q_sat [$];
        int             q_t   [$];

        matmul_seq #(
            .DATA_WIDTH (8),
            .M          (GM),
            .K          (GK),
            .N          (GN),
            .LANES      (GL),
            .SHIFT      (GSH),
            .SATURATE   (GSAT)
        ) dut (
            .clk_p     (clk),
            .rst_p     (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .matrix1   (m1),
            .matrix2   (m2),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .mul       (mul),
            .sat_flag  (sat_flag)
        );

        task automatic fill_basic();
            for (int r = 0; r < GM; r++)
                for (int k = 0; k < GK; k++) a[r][k] = r * GK + k + 1;
            for (int k = 0; k < GK; k++)
                for (int c = 0; c < GN; c++) b[k][c] = 7 + k * GN + c;
        endtask

        task automatic fill_rand();
            for (int r = 0; r < GM; r++)
                for (int k = 0; k < GK; k++) a[r][k] = int'($urandom_range(255)) - 128;
            for (int k = 0; k < GK; k++)
                for (int c = 0; c < GN; c++) b[k][c] = int'($urandom_range(255)) - 128;
        endtask

        // Compute the expected product, present operands from a negedge, return after the handshake
        task automatic send();
            logic [WO-1:0] em;
            bit            es;
            longint        s;
            int            v;
            int            n;
            em = '0;
            es = 1'b0;
            for (int r = 0; r < GM; r++) begin
                for (int c = 0; c < GN; c++) begin
                    s = 0;
                    for (int k = 0; k < GK; k++) s += longint'(a[r][k]) * longint'(b[k][c]);
                    s = s >>> GSH;
                    if (GSAT != 0) begin
                        if (s > 127) begin v = 127; es = 1'b1; end
                        else if (s < -128) begin v = -128; es = 1'b1; end
                        else v = int'(s);
                    end else begin
                        v = int'(s & 64'sd255);
                        if (v > 127) v -= 256;
                    end
                    em[(r * GN + c) * 8 +: 8] = 8'(v);
                end
            end
            for (int r = 0; r < GM; r++)
                for (int k = 0; k < GK; k++) m1[(r * GK + k) * 8 +: 8] = 8'(a[r][k]);
            for (int k = 0; k < GK; k++)
                for (int c = 0; c < GN; c++) m2[(k * GN + c) * 8 +: 8] = 8'(b[k][c]);
            in_valid = 1'b1;
            n = 0;
            while (!in_ready && n < 2000) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready) begin
                chk("in_ready_timeout", g, 0, 1);
            end else begin
                q_mul.push_back(em);
                q_sat.push_back(es);
                q_t.push_back(cyc + 1);
                @(negedge clk);
            end
            in_valid = 1'b0;
        endtask

        task automatic wait_drained();
            int n;
            n = 0;
            while (q_mul.size() != 0 && n < 5000) begin
                @(negedge clk);
                n++;
            end
            if (q_mul.size() != 0) chk("drain_timeout", g, q_mul.size(), 0);
            repeat (2) @(negedge clk);
        endtask

        // Driver: reset, directed jobs, then randomized jobs with random input gaps
        initial begin : drv
            int n;
            rst        = 1'b1;
            in_valid   = 1'b0;
            m1         = '0;
            m2         = '0;
            ready_mode = 1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            chk("rst_out_valid", g, out_valid, 0);
            chk("rst_mul", g, mul, 0);
            chk("rst_sat", g, sat_flag, 0);
            chk("rst_in_ready", g, in_ready, 0);
            @(negedge clk);
            chk("post_rst_in_ready", g, in_ready, 1);

            if (g == 2) begin
                a[0][0] = -1; a[0][1] = -2; a[0][2] = -3;
                a[1][0] = 5;  a[1][1] = -9; a[1][2] = 0;
                b[0][0] = 1;  b[0][1] = 1;
                b[1][0] = 0;  b[1][1] = 1;
                b[2][0] = 2;  b[2][1] = 2;
                send();
                for (int r = 0; r < GM; r++)
                    for (int k = 0; k < GK; k++) a[r][k] = -128;
                for (int k = 0; k < GK; k++)
                    for (int c = 0; c < GN; c++) b[k][c] = -128;
                send();
            end else if (g == 0) begin
                ready_mode = 2;
                fill_basic();
                send();
                n = 0;
                while (!out_valid && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                repeat (10) @(negedge clk);
                chk("bp_in_ready", g, in_ready, 0);
                chk("bp_out_valid", g, out_valid, 1);
                ready_mode = 1;
                wait_drained();
                // Abort a job three cycles into COMPUTE
                send();
                repeat (2) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                void'(q_mul.pop_back());
                void'(q_sat.pop_back());
                void'(q_t.pop_back());
                chk("abort_out_valid", g, out_valid, 0);
                chk("abort_mul", g, mul, 0);
                chk("abort_sat", g, sat_flag, 0);
                @(negedge clk);
                chk("abort_in_ready", g, in_ready, 1);
                fill_basic();
                send();
            end else begin
                fill_basic();
                send();
            end
            wait_drained();

            ready_mode = 0;
            for (int j = 0; j < NRAND; j++) begin
                fill_rand();
                send();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_drained();
            done_cnt++;
        end

        initial begin : rdy
            out_ready = 1'b0;
            forever begin
                @(posedge clk);
                #1;
                case (ready_mode)
                    0:       out_ready = ($urandom_range(0, 3) != 0);
                    1:       out_ready = 1'b1;
                    default: out_ready = 1'b0;
                endcase
            end
        end

        // Monitor: compare every held output cycle against the head of the scoreboard
        initial begin : mon
            bit seen;
            bit hs_prev;
            seen    = 1'b0;
            hs_prev = 1'b0;
            forever begin
                @(negedge clk);
                if (hs_prev) begin
                    chk("post_hs_out_valid", g, out_valid, 0);
                    chk("post_hs_in_ready", g, in_ready, 1);
                    hs_prev = 1'b0;
                end else if (out_valid && !rst) begin
                    if (q_mul.size() == 0) begin
                        chk("spurious_out_valid", g, out_valid, 0);
                    end else begin
                        if (!seen) chk("latency", g, cyc + 1 - q_t[0], LAT);
                        seen = 1'b1;
                        chk("mul", g, mul, q_mul[0]);
                        chk("sat_flag", g, sat_flag, q_sat[0]);
                        chk("busy_in_ready", g, in_ready, 0);
                        if (out_ready) begin
                            void'(q_mul.pop_front());
                            void'(q_sat.pop_front());
                            void'(q_t.pop_front());
                            seen    = 1'b0;
                            hs_prev = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin : main
        int n;
        errors   = 0;
        checks   = 0;
        done_cnt = 0;
        n        = 0;
        while (done_cnt < NCFG && n < 90000) begin
            @(posedge clk);
            n++;
        end
        chk("global_timeout", -1, done_cnt, NCFG);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
